board_cell_store: RTL

//  Board storage and command executor downstream of the game-control FSM. Holds per-cell state and mine map,

---
 rtl/minesweeper_pkg.sv | 35 +++
 rtl/mine_lfsr16.sv | 50 +++++
 rtl/board_cell_store.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/minesweeper_pkg.sv
// Shared types and constants for the minesweeper board datapath.
//   cell_state_t : per-cell display state (HIDDEN / FLAGGED / REVEALED)
//   dir_t        : cursor move direction encoding
//   ctrl_state_t : board controller states
//   LFSR_ALT_SEED: value loaded instead of an all-zero seed (the LFSR would lock up at 0)
//   lfsr_feedback: feedback bit of the 16-bit Fibonacci LFSR, taps 16,14,13,11
package minesweeper_pkg;

  typedef enum logic [1:0] {
    HIDDEN   = 2'b00,
    FLAGGED  = 2'b01,
    REVEALED = 2'b10
  } cell_state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INIT  = 2'b01,
    READY = 2'b10
  } ctrl_state_t;

  localparam logic [15:0] LFSR_ALT_SEED = 16'hACE1;

  // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
  function automatic logic lfsr_feedback(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

endpackage

// File: rtl/mine_lfsr16.sv
// 16-bit Fibonacci LFSR used to scatter mines while the board is seeded.
// Ports:
//   clk, rst (async, active-low)
//   load  : load seed (an all-zero seed is replaced by LFSR_ALT_SEED)
//   seed  : seed value sampled when load is high
//   step  : advance one position (shift left, feedback into bit 0)
//   q     : current register contents
// load has priority over step.
module mine_lfsr16
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next-state selection: load, step or hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      if (seed == 16'h0000) begin
        q_d = LFSR_ALT_SEED;
      end else begin
        q_d = seed;
      end
    end else if (step) begin
      q_d = {q_q[14:0], lfsr_feedback(q_q)};
    end else begin
      q_d = q_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= LFSR_ALT_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/board_cell_store.sv
// Board storage and command executor sitting behind the game-control FSM.
// Holds the per-cell state and mine map, seeds the board one cell per cycle
// after start, moves the cursor and applies flag/clear commands, and reports
// the cursor cell back to the FSM. A separate read port serves the display.
//
// Ports:
//   clk, rst (async, active-low)
//   start, seed             : begin seeding; seed sampled with start
//   cmd_move, move_dir      : cursor move (00 up, 01 down, 10 left, 11 right)
//   cmd_flag, cmd_clear     : toggle flag / reveal the cursor cell
//   rd_row, rd_col          : display read address
//   init_busy               : seeding in progress
//   ultima_casilla          : high in the cycle the last cell is seeded
//   cur_row, cur_col        : cursor position
//   hay_bomba, hay_bandera  : cursor cell is a mine / is flagged
//   rd_state, rd_mine       : cell at the read address (HIDDEN/0 when out of range)
//   revealed_cnt            : number of revealed cells, saturating at 255
//   cmd_done                : one-cycle pulse the cycle after an accepted command
//   adj_count               : mines around the cursor
//
// Build option: define BOARD_ADJ_COUNT_EN to compute adj_count from the
// in-range 8-neighbourhood of the cursor; otherwise adj_count is 0 and no
// neighbour logic exists. The port list is the same in both builds.
module board_cell_store
  import minesweeper_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DENSITY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic        cmd_move,
  input  logic [1:0]  move_dir,
  input  logic        cmd_flag,
  input  logic        cmd_clear,
  input  logic [3:0]  rd_row,
  input  logic [3:0]  rd_col,
  output logic        init_busy,
  output logic        ultima_casilla,
  output logic [3:0]  cur_row,
  output logic [3:0]  cur_col,
  output logic        hay_bomba,
  output logic        hay_bandera,
  output logic [1:0]  rd_state,
  output logic        rd_mine,
  output logic [7:0]  revealed_cnt,
  output logic        cmd_done,
  output logic [3:0]  adj_count
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IW     = $clog2(NCELLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCELLS - 1);

  // Row-major cell index.
  function automatic logic [IW-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return IW'(int'(r) * COLS + int'(c));
  endfunction

  ctrl_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  cell_state_t     cell_q [NCELLS];
  cell_state_t     cell_d [NCELLS];
  logic [NCELLS-1:0] mine_q, mine_d;
  logic [3:0]      cur_row_q, cur_row_d;
  logic [3:0]      cur_col_q, cur_col_d;
  logic [7:0]      revealed_q, revealed_d;
  logic            cmd_done_q, cmd_done_d;

  logic            lfsr_load_s;
  logic            lfsr_step_s;
  logic [15:0]     lfsr_s;
  logic            lfsr_mine_s;
  logic            lfsr_unused_s;
  logic [IW-1:0]   cur_idx_s;
  logic [IW-1:0]   rd_idx_s;

  mine_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load_s),
    .seed (seed),
    .step (lfsr_step_s),
    .q    (lfsr_s)
  );

  // Only the low nibble decides mine placement.
  assign lfsr_mine_s   = (int'(lfsr_s[3:0]) < DENSITY);
  assign lfsr_unused_s = ^lfsr_s[15:4];
  assign cur_idx_s     = cell_idx(cur_row_q, cur_col_q);
  assign rd_idx_s      = cell_idx(rd_row, rd_col);

  // Controller next state: start always (re)enters INIT; commands only act in READY.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cell_d      = cell_q;
    mine_d      = mine_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    revealed_d  = revealed_q;
    cmd_done_d  = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    if (start) begin
      state_d     = INIT;
      idx_d       = {IW{1'b0}};
      cur_row_d   = 4'd0;
      cur_col_d   = 4'd0;
      revealed_d  = 8'd0;
      lfsr_load_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        INIT: begin
          cell_d[idx_q] = HIDDEN;
          mine_d[idx_q] = lfsr_mine_s;
          lfsr_step_s   = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = READY;
            idx_d   = {IW{1'b0}};
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        READY: begin
          if (cmd_move) begin
            cmd_done_d = 1'b1;
            // Moves saturate at the board edges.
            case (dir_t'(move_dir))
              UP: begin
                if (cur_row_q != 4'd0) cur_row_d = cur_row_q - 4'd1;
                else                   cur_row_d = cur_row_q;
              end
              DOWN: begin
                if (cur_row_q != 4'(ROWS - 1)) cur_row_d = cur_row_q + 4'd1;
                else                            cur_row_d = cur_row_q;
              end
              LEFT: begin
                if (cur_col_q != 4'd0) cur_col_d = cur_col_q - 4'd1;
                else                   cur_col_d = cur_col_q;
              end
              RIGHT: begin
                if (cur_col_q != 4'(COLS - 1)) cur_col_d = cur_col_q + 4'd1;
                else                            cur_col_d = cur_col_q;
              end
              default: begin
                cur_row_d = cur_row_q;
                cur_col_d = cur_col_q;
              end
            endcase
          end else if (cmd_flag) begin
            cmd_done_d = 1'b1;
            case (cell_q[cur_idx_s])
              HIDDEN:  cell_d[cur_idx_s] = FLAGGED;
              FLAGGED: cell_d[cur_idx_s] = HIDDEN;
              default: cell_d[cur_idx_s] = cell_q[cur_idx_s];
            endcase
          end else if (cmd_clear) begin
            cmd_done_d = 1'b1;
            if (cell_q[cur_idx_s] == HIDDEN) begin
              cell_d[cur_idx_s] = REVEALED;
              if (revealed_q != 8'hFF) revealed_d = revealed_q + 8'd1;
              else                     revealed_d = revealed_q;
            end else begin
              cell_d[cur_idx_s] = cell_q[cur_idx_s];
            end
          end else begin
            cmd_done_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, board storage and cursor registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= {IW{1'b0}};
      mine_q     <= {NCELLS{1'b0}};
      cur_row_q  <= 4'd0;
      cur_col_q  <= 4'd0;
      revealed_q <= 8'd0;
      cmd_done_q <= 1'b0;
      for (int i = 0; i < NCELLS; i++) begin
        cell_q[i] <= HIDDEN;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mine_q     <= mine_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      revealed_q <= revealed_d;
      cmd_done_q <= cmd_done_d;
      cell_q     <= cell_d;
    end
  end

  // Display read port; out-of-range addresses read as an empty hidden cell.
  always_comb begin
    rd_state = HIDDEN;
    rd_mine  = 1'b0;
    if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) begin
      rd_state = cell_q[rd_idx_s];
      rd_mine  = mine_q[rd_idx_s];
    end else begin
      rd_state = HIDDEN;
      rd_mine  = 1'b0;
    end
  end

`ifdef BOARD_ADJ_COUNT_EN
  logic [3:0] adj_s;

  // Count mines in the in-range neighbours of the cursor.
  always_comb begin
    adj_s = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (((dr != 0) || (dc != 0)) &&
            (int'(cur_row_q) + dr >= 0) && (int'(cur_row_q) + dr < ROWS) &&
            (int'(cur_col_q) + dc >= 0) && (int'(cur_col_q) + dc < COLS)) begin
          adj_s = adj_s + {3'b000,
                  mine_q[IW'((int'(cur_row_q) + dr) * COLS + int'(cur_col_q) + dc)]};
        end else begin
          adj_s = adj_s;
        end
      end
    end
  end

  assign adj_count = adj_s;
`else
  assign adj_count = 4'd0;
`endif

  assign init_busy      = (state_q == INIT);
  assign ultima_casilla = (state_q == INIT) && (idx_q == LAST_IDX) && !start;
  assign cur_row        = cur_row_q;
  assign cur_col        = cur_col_q;
  assign hay_bomba      = mine_q[cur_idx_s];
  assign hay_bandera    = (cell_q[cur_idx_s] == FLAGGED);
  assign revealed_cnt   = revealed_q;
  assign cmd_done       = cmd_done_q;

endmodule
